// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out: an accepted word emits bit 0 one cycle after accept, then one bit per clock.
// load_ready only in IDLE or the last frame cycle. Define SERIALIZER_PARITY_EN for a trailing even-parity bit.
module piso_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, shifted;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             sout_nxt, valid_nxt, done_nxt;
  logic             last_bit, reload_win;
`ifdef SERIALIZER_PARITY_EN
  logic             par, par_nxt;
`endif

  assign last_bit = (state == SHIFT) && (cnt == LAST);
`ifdef SERIALIZER_PARITY_EN
  assign reload_win = (state == PAR);
`else
  assign reload_win = last_bit;
`endif
  assign load_ready = !rst && ((state == IDLE) || reload_win);
  assign shifted    = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
`ifdef SERIALIZER_PARITY_EN
    par_nxt   = par;
`endif
    if (load_valid && load_ready) begin
      state_nxt = SHIFT;
      shreg_nxt = din;
      cnt_nxt   = '0;
`ifdef SERIALIZER_PARITY_EN
      par_nxt   = ^din;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (last_bit) begin
`ifdef SERIALIZER_PARITY_EN
            state_nxt = PAR;
`else
            state_nxt = IDLE;
`endif
            shreg_nxt = '0;
            cnt_nxt   = '0;
          end else begin
            shreg_nxt = shifted;
            cnt_nxt   = cnt + CW'(1);
          end
        end
`ifdef SERIALIZER_PARITY_EN
        PAR: state_nxt = IDLE;
`endif
        default: ;
      endcase
    end

    // Outputs are precomputed from next-state so they leave straight from flops.
    valid_nxt = (state_nxt != IDLE);
    sout_nxt  = MSB_FIRST ? shreg_nxt[WIDTH-1] : shreg_nxt[0];
`ifdef SERIALIZER_PARITY_EN
    if (state_nxt == PAR) sout_nxt = par_nxt;
    done_nxt  = (state_nxt == PAR);
`else
    done_nxt  = (state_nxt == SHIFT) && (cnt_nxt == LAST);
`endif
    if (state_nxt == IDLE) sout_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      frame_done <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      cnt        <= cnt_nxt;
      sout       <= sout_nxt;
      sout_valid <= valid_nxt;
      frame_done <= done_nxt;
`ifdef SERIALIZER_PARITY_EN
      par        <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed bench for piso_bit_serializer: one MSB-first and one LSB-first instance on shared inputs.
module tb_piso_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  localparam int FL = 8 + (PE ? 1 : 0);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;
  logic       load_valid = 1'b0;
  logic       m_load_ready, m_sout, m_valid, m_done;
  logic       l_load_ready, l_sout, l_valid, l_done;
  int         checks = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(m_load_ready), .sout(m_sout), .sout_valid(m_valid), .frame_done(m_done)
  );

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(l_load_ready), .sout(l_sout), .sout_valid(l_valid), .frame_done(l_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (m_load_ready !== 1'b1) $display("FAIL reset idle load_ready: got %b exp 1", m_load_ready); else passed++;
    checks++; if (m_valid !== 1'b0) $display("FAIL reset idle sout_valid: got %b exp 0", m_valid); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (m_sout !== 1'b0) $display("FAIL reset sout: got %b exp 0", m_sout); else passed++;
    checks++; if (m_valid !== 1'b0) $display("FAIL reset sout_valid: got %b exp 0", m_valid); else passed++;
    checks++; if (m_done !== 1'b0) $display("FAIL reset frame_done: got %b exp 0", m_done); else passed++;
    checks++; if (m_load_ready !== 1'b0) $display("FAIL reset load_ready: got %b exp 0", m_load_ready); else passed++;
    #1 rst = 1'b0;
    #1;
    checks++; if (m_load_ready !== 1'b1) $display("FAIL reset release load_ready: got %b exp 1", m_load_ready); else passed++;
    tick();
  endtask

  task automatic test_single_frame();
    logic [7:0] w;
    logic       eb;
    w = 8'hF0;
    din = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      eb = (k < 8) ? w[7-k] : ^w;
      checks++; if (m_sout !== eb) $display("FAIL single sout cyc%0d: got %b exp %b", k+1, m_sout, eb); else passed++;
      checks++; if (m_valid !== 1'b1) $display("FAIL single sout_valid cyc%0d: got %b exp 1", k+1, m_valid); else passed++;
      checks++; if (m_done !== (k == FL-1)) $display("FAIL single frame_done cyc%0d: got %b exp %b", k+1, m_done, (k == FL-1)); else passed++;
      tick();
    end
    checks++; if (m_sout !== 1'b0) $display("FAIL single idle sout: got %b exp 0", m_sout); else passed++;
    checks++; if (m_valid !== 1'b0) $display("FAIL single idle sout_valid: got %b exp 0", m_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0, w1, wk;
    logic       eb;
    int         j;
    w0 = 8'h0F;
    w1 = 8'hF0;
    din = w0;
    load_valid = 1'b1;
    tick();
    din = w1;
    for (int k = 0; k < 2*FL; k++) begin
      wk = (k < FL) ? w0 : w1;
      j  = k % FL;
      eb = (j < 8) ? wk[7-j] : ^wk;
      checks++; if (m_sout !== eb) $display("FAIL b2b sout cyc%0d: got %b exp %b", k+1, m_sout, eb); else passed++;
      checks++; if (m_valid !== 1'b1) $display("FAIL b2b sout_valid cyc%0d: got %b exp 1", k+1, m_valid); else passed++;
      checks++; if (m_done !== (j == FL-1)) $display("FAIL b2b frame_done cyc%0d: got %b exp %b", k+1, m_done, (j == FL-1)); else passed++;
      if (k == 2*FL-1) load_valid = 1'b0;
      tick();
    end
    checks++; if (m_valid !== 1'b0) $display("FAIL b2b idle sout_valid: got %b exp 0", m_valid); else passed++;
  endtask

  task automatic test_busy_ignore();
    logic [7:0] w;
    logic       eb;
    w = 8'hAA;
    din = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      if (k == 2) begin
        din = 8'hFF;
        load_valid = 1'b1;
        checks++; if (m_load_ready !== 1'b0) $display("FAIL busy load_ready cyc3: got %b exp 0", m_load_ready); else passed++;
      end
      if (k == 3) load_valid = 1'b0;
      eb = (k < 8) ? w[7-k] : ^w;
      checks++; if (m_sout !== eb) $display("FAIL busy sout cyc%0d: got %b exp %b", k+1, m_sout, eb); else passed++;
      checks++; if (m_done !== (k == FL-1)) $display("FAIL busy frame_done cyc%0d: got %b exp %b", k+1, m_done, (k == FL-1)); else passed++;
      tick();
    end
    checks++; if (m_valid !== 1'b0) $display("FAIL busy idle sout_valid: got %b exp 0", m_valid); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w;
    logic       eb;
    din = 8'hFF;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    checks++; if (m_valid !== 1'b1) $display("FAIL midrst frame start sout_valid: got %b exp 1", m_valid); else passed++;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (m_sout !== 1'b0) $display("FAIL midrst sout: got %b exp 0", m_sout); else passed++;
    checks++; if (m_valid !== 1'b0) $display("FAIL midrst sout_valid: got %b exp 0", m_valid); else passed++;
    checks++; if (m_load_ready !== 1'b0) $display("FAIL midrst load_ready: got %b exp 0", m_load_ready); else passed++;
    #1 rst = 1'b0;
    #1;
    checks++; if (m_load_ready !== 1'b1) $display("FAIL midrst release load_ready: got %b exp 1", m_load_ready); else passed++;
    tick();
    checks++; if (m_valid !== 1'b0) $display("FAIL midrst no resume sout_valid: got %b exp 0", m_valid); else passed++;
    w = 8'h81;
    din = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      eb = (k < 8) ? w[7-k] : ^w;
      checks++; if (m_sout !== eb) $display("FAIL midrst clean sout cyc%0d: got %b exp %b", k+1, m_sout, eb); else passed++;
      checks++; if (m_valid !== 1'b1) $display("FAIL midrst clean sout_valid cyc%0d: got %b exp 1", k+1, m_valid); else passed++;
      tick();
    end
    checks++; if (m_valid !== 1'b0) $display("FAIL midrst clean idle sout_valid: got %b exp 0", m_valid); else passed++;
  endtask

  task automatic test_lsb_parity();
    logic [7:0] w;
    logic       eb, er;
    w = 8'h07;
    din = w;
    load_valid = 1'b1;
    checks++; if (l_load_ready !== 1'b1) $display("FAIL lsb idle load_ready: got %b exp 1", l_load_ready); else passed++;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      eb = (k < 8) ? w[k] : ^w;
      checks++; if (l_sout !== eb) $display("FAIL lsb sout cyc%0d: got %b exp %b", k+1, l_sout, eb); else passed++;
      checks++; if (l_valid !== 1'b1) $display("FAIL lsb sout_valid cyc%0d: got %b exp 1", k+1, l_valid); else passed++;
      checks++; if (l_done !== (k == FL-1)) $display("FAIL lsb frame_done cyc%0d: got %b exp %b", k+1, l_done, (k == FL-1)); else passed++;
      if (k >= 7) begin
        er = (k == FL-1);
        checks++; if (l_load_ready !== er) $display("FAIL lsb load_ready cyc%0d: got %b exp %b", k+1, l_load_ready, er); else passed++;
      end
      tick();
    end
    checks++; if (l_sout !== 1'b0) $display("FAIL lsb idle sout: got %b exp 0", l_sout); else passed++;
    checks++; if (l_valid !== 1'b0) $display("FAIL lsb idle sout_valid: got %b exp 0", l_valid); else passed++;
  endtask

  initial begin
    #1 rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    test_lsb_parity();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
